// File: rtl/fp8_sched_pkg.sv
// fp8_sched_pkg: shared opcodes, requester ID type and FP8 E4M3 constants
package fp8_sched_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;
  typedef logic [0:0] req_id_t;
  localparam logic [7:0] ONE  = 8'h38;
  localparam logic [7:0] TWO  = 8'h40;
  localparam logic [7:0] ZERO = 8'h00;
endpackage

// File: rtl/fp8_rsp_fifo.sv
// fp8_rsp_fifo: registered response FIFO, no fall-through, pop frees a slot for a same-cycle push
module fp8_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd];
  // storage is left unreset; empty masks the stale head
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // read/write pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd + AW'(do_pop);
      wr    <= wr + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/fp8_op_scheduler.sv
// fp8_op_scheduler: round-robin sharing of one FP8 unit between two credit-limited requesters
module fp8_op_scheduler
  import fp8_sched_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [1:0]     req_op,
  output logic           u_valid,
  output logic [W-1:0]   u_a,
  output logic [W-1:0]   u_b,
  output logic           u_op,
  output req_id_t        u_tag,
  input  logic           u_res_valid,
  input  logic [W-1:0]   u_res,
  input  req_id_t        u_res_tag,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           err
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [1:0][CW-1:0] cnt;
  logic [1:0] elig, grant, push, pop, full, empty;
  logic prio, bad_res, overflow;
  req_id_t sel;
  for (genvar i = 0; i < 2; i++) begin : g_req
    assign elig[i] = rst_n && ena && req_valid[i] && cnt[i] < CW'(DEPTH);
    assign pop[i]  = rsp_ready[i] && !empty[i];
    assign push[i] = u_res_valid && u_res_tag == req_id_t'(i) && cnt[i] != '0;
    fp8_rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (u_res),
      .dout  (rsp_data[i*W +: W]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end
  assign grant     = &elig ? (prio ? 2'b10 : 2'b01) : elig;
  assign req_ready = grant;
  assign sel       = req_id_t'(grant[1]);
  assign rsp_valid = ~empty;
  assign bad_res   = u_res_valid && cnt[u_res_tag] == '0;
  assign overflow  = |(push & full & ~pop);
  // credits: +1 on issue, -1 when a buffered response is consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else for (int k = 0; k < 2; k++) cnt[k] <= cnt[k] + CW'(grant[k]) - CW'(pop[k]);
  // registered issue to the unit; priority passes to the other requester after a grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      u_valid <= 1'b0;
      u_a     <= '0;
      u_b     <= '0;
      u_op    <= 1'b0;
      u_tag   <= '0;
      prio    <= 1'b0;
    end else begin
      u_valid <= |grant;
      prio    <= |grant ? ~sel : prio;
      if (|grant) begin
        u_a   <= sel ? req_a[2*W-1:W] : req_a[W-1:0];
        u_b   <= sel ? req_b[2*W-1:W] : req_b[W-1:0];
        u_op  <= req_op[sel];
        u_tag <= sel;
      end
    end
  // sticky protocol error: result without credit, or push into a full FIFO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else err <= err | bad_res | overflow;
endmodule

// File: tb/tb_fp8_op_scheduler.sv
// tb_fp8_op_scheduler: randomized bench with a queue-based scoreboard of the scheduler
module tb_fp8_op_scheduler;
  import fp8_sched_pkg::*;
  localparam int W = 8, DEPTH = 4;
  logic clk = 0, rst_n = 0, ena = 0;
  logic [1:0] req_valid = 0, req_op = 0, rsp_ready = 0;
  logic [2*W-1:0] req_a = 0, req_b = 0;
  logic [1:0] req_ready, rsp_valid;
  logic u_valid, u_op, err;
  logic u_tag;
  logic u_res_valid = 0, u_res_tag = 0;
  logic [W-1:0] u_a, u_b, u_res = 0;
  logic [2*W-1:0] rsp_data;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  fp8_op_scheduler #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .u_valid(u_valid), .u_a(u_a), .u_b(u_b),
    .u_op(u_op), .u_tag(u_tag), .u_res_valid(u_res_valid), .u_res(u_res), .u_res_tag(u_res_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .err(err)
  );

  logic f_push = 0, f_pop = 0, f_full, f_empty;
  logic [W-1:0] f_din = 0, f_dout;
  fp8_rsp_fifo #(.W(W), .DEPTH(DEPTH)) fifo_i (
    .clk(clk), .rst_n(rst_n), .push(f_push), .pop(f_pop), .din(f_din),
    .dout(f_dout), .full(f_full), .empty(f_empty)
  );

  // behavioural FP8 unit: any fixed mapping works; 1.0 * x returns x
  function automatic logic [7:0] fn(input logic [7:0] a, input logic [7:0] b, input logic op);
    return op == OP_ADD ? a + b : (a == ONE ? b : a ^ b);
  endfunction

  // unit model: in-order results after a short latency, plus a manual injection path
  typedef struct { logic tag; logic [7:0] res; int rdy; } ures_t;
  ures_t uq[$];
  ures_t ue;
  int cyc = 0;
  logic unit_on = 0, inj_on = 0, inj_tag = 0;
  always begin
    @(negedge clk);
    if (!rst_n) uq.delete();
    else if (u_valid) uq.push_back('{u_tag, fn(u_a, u_b, u_op), cyc + 1});
    @(posedge clk);
    cyc++;
    #3;
    if (!rst_n) u_res_valid = 0;
    else if (inj_on) begin
      u_res_valid = 1; u_res_tag = inj_tag; u_res = 8'hA5;
    end else if (unit_on && uq.size() > 0 && uq[0].rdy <= cyc) begin
      ue = uq.pop_front();
      u_res_valid = 1; u_res_tag = ue.tag; u_res = ue.res;
    end else u_res_valid = 0;
  end

  // scoreboard: exp_q[i] holds every outstanding result of requester i in request order;
  // the first nbuf[i] of them have come back from the unit and sit in the response FIFO
  logic [7:0] exp_q [2][$];
  int nbuf [2];
  logic prio_m = 0, err_m = 0, iss_pend = 0, iop = 0, itag = 0, m_t;
  logic [7:0] ia = 0, ib = 0;
  logic [1:0] m_el, m_g, m_pp;
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin exp_q[i].delete(); nbuf[i] = 0; end
      prio_m = 0; err_m = 0; iss_pend = 0;
    end else begin
      for (int i = 0; i < 2; i++) m_el[i] = ena && req_valid[i] && exp_q[i].size() < DEPTH;
      m_g = (m_el == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : m_el;
      checks++;
      if (req_ready !== m_g) begin
        errors++; $display("FAIL grant: req_ready=%b expected %b at %0t", req_ready, m_g, $time);
      end
      checks++;
      if (u_valid !== iss_pend || (iss_pend && {u_a, u_b, u_op, u_tag} !== {ia, ib, iop, itag})) begin
        errors++;
        $display("FAIL issue: u_valid=%b a=%h b=%h op=%b tag=%b expected %b %h %h %b %b at %0t",
                 u_valid, u_a, u_b, u_op, u_tag, iss_pend, ia, ib, iop, itag, $time);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rsp_valid[i] !== (nbuf[i] > 0) || (nbuf[i] > 0 && rsp_data[i*W +: W] !== exp_q[i][0])) begin
          errors++;
          $display("FAIL rsp%0d: valid=%b data=%h expected valid=%b data=%h at %0t", i, rsp_valid[i],
                   rsp_data[i*W +: W], nbuf[i] > 0, nbuf[i] > 0 ? exp_q[i][0] : 8'h00, $time);
        end
      end
      checks++;
      if (err !== err_m) begin
        errors++; $display("FAIL err: err=%b expected %b at %0t", err, err_m, $time);
      end
      for (int i = 0; i < 2; i++) m_pp[i] = nbuf[i] > 0 && rsp_ready[i];
      if (u_res_valid) begin
        m_t = u_res_tag;
        if (exp_q[m_t].size() == 0) err_m = 1;
        else if (nbuf[m_t] == DEPTH && !m_pp[m_t]) err_m = 1;
        else nbuf[m_t]++;
      end
      for (int i = 0; i < 2; i++) if (m_pp[i]) begin void'(exp_q[i].pop_front()); nbuf[i]--; end
      iss_pend = |m_g;
      if (|m_g) begin
        itag = m_g[1];
        ia = req_a[int'(itag)*W +: W]; ib = req_b[int'(itag)*W +: W]; iop = req_op[itag];
        exp_q[itag].push_back(fn(ia, ib, iop));
        prio_m = m_g[0];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 0; ena = 0; req_valid = 0; rsp_ready = 0; unit_on = 0; inj_on = 0;
    tick(); tick();
    rst_n = 1; ena = 1;
  endtask

  task automatic randomize_ops();
    req_a = 16'($urandom); req_b = 16'($urandom); req_op = 2'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 1; req_valid = 2'b11; randomize_ops();
    tick(); tick(); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: %b expected 00", req_ready); end
    checks++; if ({u_valid, u_a, u_b, u_op, u_tag} !== '0) begin
      errors++; $display("FAIL reset_issue: %b %h %h %b %b expected zeros", u_valid, u_a, u_b, u_op, u_tag);
    end
    checks++; if ({rsp_valid, rsp_data} !== '0) begin errors++; $display("FAIL reset_rsp: %b %h expected zeros", rsp_valid, rsp_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: %b expected 0", err); end
    req_valid = 0;
  endtask

  task automatic test_single_op();
    int got;
    do_reset(); unit_on = 1;
    req_a[7:0] = ONE; req_b[7:0] = TWO; req_op[0] = OP_MUL; req_valid = 2'b01; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: %b expected 01", req_ready); end
    tick(); req_valid = 0; #1;
    checks++; if ({u_valid, u_op, u_tag} !== 3'b100) begin
      errors++; $display("FAIL single_issue: valid=%b op=%b tag=%b expected 1 0 0", u_valid, u_op, u_tag);
    end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); #1; got = rsp_valid[0]; end
    checks++; if (!got) begin errors++; $display("FAIL single_rsp_timeout: rsp_valid[0]=0 expected 1"); end
    checks++; if (rsp_data[7:0] !== TWO) begin errors++; $display("FAIL single_data: %h expected %h", rsp_data[7:0], TWO); end
    tick(); rsp_ready = 2'b01; tick(); rsp_ready = 0; tick();
  endtask

  task automatic test_contention();
    logic [1:0] gs [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset(); unit_on = 1; rsp_ready = 2'b11; req_valid = 2'b11; randomize_ops();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req_valid = 0;
      #1;
      if (k < 4) begin
        checks++; if (req_ready !== gs[k]) begin errors++; $display("FAIL contention_grant%0d: %b expected %b", k, req_ready, gs[k]); end
      end
      if (k > 0) begin
        checks++; if (!u_valid || u_tag !== gs[k-1][1]) begin
          errors++; $display("FAIL contention_tag%0d: valid=%b tag=%b expected 1 %b", k - 1, u_valid, u_tag, gs[k-1][1]);
        end
      end
      tick(); randomize_ops();
    end
    repeat (10) tick();
  endtask

  task automatic test_credit_stall();
    do_reset(); unit_on = 1; rsp_ready = 0; req_valid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      randomize_ops(); #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL credit_fill%0d: %b expected 10", k, req_ready); end
      tick();
    end
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL credit_block: %b expected 00", req_ready); end
    tick(); req_valid = 2'b11; randomize_ops(); #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL credit_other: %b expected 01", req_ready); end
    tick(); req_valid = 2'b10;
    repeat (10) tick();
    rsp_ready = 2'b10; #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL credit_pop_cycle: %b expected 00", req_ready); end
    tick(); rsp_ready = 0; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL credit_regrant: %b expected 10", req_ready); end
    tick(); req_valid = 0; rsp_ready = 2'b11;
    repeat (15) tick();
  endtask

  task automatic test_push_pop();
    logic [7:0] ref_q[$];
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      f_din = 8'($urandom); f_push = 1; ref_q.push_back(f_din); tick();
    end
    f_push = 0; #1;
    checks++; if (f_full !== 1'b1) begin errors++; $display("FAIL fifo_full: %b expected 1", f_full); end
    f_push = 1; f_pop = 1; f_din = 8'($urandom); #1;
    checks++; if (f_dout !== ref_q[0]) begin errors++; $display("FAIL fifo_head: %h expected %h", f_dout, ref_q[0]); end
    void'(ref_q.pop_front()); ref_q.push_back(f_din);
    tick(); f_push = 0; f_pop = 0; #1;
    checks++; if (f_full !== 1'b1) begin errors++; $display("FAIL fifo_still_full: %b expected 1", f_full); end
    for (int k = 0; k < DEPTH; k++) begin
      f_pop = 1; #1;
      checks++; if (f_dout !== ref_q[0]) begin errors++; $display("FAIL fifo_order%0d: %h expected %h", k, f_dout, ref_q[0]); end
      void'(ref_q.pop_front()); tick();
    end
    f_pop = 0; #1;
    checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fifo_empty: %b expected 1", f_empty); end
    f_push = 1; f_pop = 1; f_din = 8'h5C; #1;
    checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fifo_no_fallthrough: empty=%b expected 1", f_empty); end
    tick(); f_push = 0; f_pop = 0; #1;
    checks++; if (f_empty !== 1'b0 || f_dout !== 8'h5C) begin
      errors++; $display("FAIL fifo_empty_pushpop: empty=%b dout=%h expected 0 5c", f_empty, f_dout);
    end
    f_pop = 1; tick(); f_pop = 0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fifo_err: %b expected 0", err); end
  endtask

  task automatic test_ena_low();
    int got;
    do_reset(); unit_on = 0; rsp_ready = 0; req_valid = 2'b01;
    for (int k = 0; k < 2; k++) begin
      randomize_ops(); #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ena_issue%0d: %b expected 01", k, req_ready); end
      tick();
    end
    ena = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ena_block%0d: %b expected 00", k, req_ready); end
      if (k > 0) begin
        checks++; if (u_valid !== 1'b0) begin errors++; $display("FAIL ena_uvalid%0d: %b expected 0", k, u_valid); end
      end
      tick();
    end
    unit_on = 1; rsp_ready = 2'b01; got = 0;
    for (int k = 0; k < 20; k++) begin #1; if (rsp_valid[0]) got++; tick(); end
    checks++; if (got != 2) begin errors++; $display("FAIL ena_drain: %0d responses expected 2", got); end
    req_valid = 0; rsp_ready = 0; ena = 1;
  endtask

  task automatic test_error_reset();
    do_reset(); inj_tag = 1; inj_on = 1; tick(); inj_on = 0; #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: %b expected 1", err); end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky%0d: %b expected 1", k, err); end
    end
    tick(); unit_on = 1; req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin randomize_ops(); tick(); end
    rst_n = 0; #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL arst_ready: %b expected 00", req_ready); end
    checks++; if ({u_valid, u_a, u_b, u_op, u_tag} !== '0) begin
      errors++; $display("FAIL arst_issue: %b %h %h %b %b expected zeros", u_valid, u_a, u_b, u_op, u_tag);
    end
    checks++; if ({rsp_valid, rsp_data} !== '0) begin errors++; $display("FAIL arst_rsp: %b %h expected zeros", rsp_valid, rsp_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err: %b expected 0", err); end
    tick(); req_valid = 0; rst_n = 1; tick();
    inj_tag = 0; inj_on = 1; tick(); inj_on = 0; #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL late_result_err: %b expected 1", err); end
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_credit_stall();
    test_push_pop();
    test_ena_low();
    test_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp8_op_scheduler.md
# fp8_op_scheduler

Round-robin scheduler that shares one FP8 arithmetic unit (E4M3, 8-bit operands) between two requester ports in the lightFP8 design. It sits between the pin-level operand capture logic and the FP8 add/mul datapath. Each requester gets credit-based flow control. Results are routed back to the issuing requester through a per-requester response FIFO.

## Interface
Parameters:
- W, 8: operand/result width.
- DEPTH, 4: per-requester credit limit and response FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  single clock; every register is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ena  in  1  high = new grants allowed; low = no new grants, in-flight work still completes.
- req_valid  in  2  bit i = requester i has an operation.
- req_ready  out  2  bit i = operation from requester i accepted this cycle.
- req_a, req_b  in  2*W  operands; slice [i*W +: W] belongs to requester i.
- req_op  in  2  bit i: 0 = multiply, 1 = add.
- u_valid  out  1  issue strobe to the unit (one cycle per operation).
- u_a, u_b  out  W  operands issued to the unit.
- u_op  out  1  operation issued to the unit.
- u_tag  out  1  ID of the requester that issued the operation.
- u_res_valid  in  1  result strobe from the unit.
- u_res  in  W  result from the unit.
- u_res_tag  in  1  tag returned with the result.
- rsp_valid  out  2  bit i = response FIFO i is non-empty.
- rsp_ready  in  2  bit i = requester i consumes its head entry.
- rsp_data  out  2*W  head of response FIFO i, in slice [i*W +: W].
- err  out  1  sticky protocol error flag; cleared only by reset.

## Operation
- Credit counter cnt[i] (0..DEPTH) counts in-flight operations plus buffered responses for requester i.
  - +1 on issue from requester i.
  - −1 on rsp_valid[i] && rsp_ready[i].
  - Both in the same cycle: no change.
- eligible[i] = ena && req_valid[i] && cnt[i] < DEPTH.
- Grant is combinational:
  - Only one requester eligible: it wins.
  - Both eligible: requester prio wins.
  - req_ready[i] = grant[i]. req_ready may depend on req_valid. At most one bit of req_ready is high.
- After a grant to requester i, prio becomes 1−i. With no grant, prio holds.
- The unit returns results in issue order, one per u_res_valid. Each result is pushed into FIFO u_res_tag.
- The credit limit guarantees no FIFO overflow. err is set (sticky) on either condition:
  - u_res_valid with cnt[tag] == 0;
  - a push to a full FIFO. The push is dropped.
- Per-requester responses come out in request order.

## Timing
- Reset values:
  - req_ready = 0, u_valid = 0, u_a = 0, u_b = 0, u_op = 0, u_tag = 0.
  - rsp_valid = 0, rsp_data = 0, err = 0.
  - cnt = 0, FIFOs empty, prio = 0.
- Issue latency:
  - Handshake in cycle N.
  - u_valid, u_a, u_b, u_op, u_tag are registered and high/valid in cycle N+1 only.
- Back-to-back accepts are allowed (one per cycle).
- Response latency:
  - u_res_valid in cycle M → rsp_valid[tag] high in cycle M+1.
  - The FIFO is registered; there is no fall-through path.
- Push and pop on the same FIFO in one cycle:
  - Full: legal. The pop frees a slot.
  - Empty: the pushed entry becomes visible in the next cycle.
- The credit check uses the registered cnt. A slot freed by a pop in cycle N is usable for a grant in cycle N+1.
- ena deasserted mid-stream: grants stop in that same cycle; outstanding results still land and drain.
- Asynchronous reset mid-operation discards all in-flight state. Results that arrive after reset release set err (cnt = 0).

## Structure
- Package fp8_sched_pkg:
  - constants OP_MUL = 1'b0, OP_ADD = 1'b1;
  - requester ID type (1 bit);
  - FP8 E4M3 constants for benches: ONE = 8'h38, TWO = 8'h40, ZERO = 8'h00.
- Sub-module fp8_rsp_fifo (parameters W, DEPTH): synchronous FIFO with async reset, push/pop/full/empty. Instantiated twice.

## Test plan
- Single op: requester 0 sends a=8'h38, b=8'h40, mul. Expected:
  - req_ready[0] high in the same cycle;
  - next cycle u_valid=1, u_op=0, u_tag=0;
  - after the bench unit model returns 8'h40, rsp_valid[0]=1, rsp_data[0]=8'h40 one cycle later.
- Contention: both requesters hold valid for 4 cycles. Expected grant sequence 0,1,0,1 and u_tag 0,1,0,1.
- Credit stall: requester 1 issues 4 ops with rsp_ready[1]=0. Expected:
  - 5th request sees req_ready[1]=0;
  - requester 0 is still served;
  - one pop on requester 1 → grant on the next cycle.
- Simultaneous push/pop: FIFO 0 full; pop in the same cycle as the next result arrives. Expected: occupancy stays at DEPTH, order preserved, err=0.
- ena low: drop ena with 2 ops in flight. Expected: no new u_valid; both responses still delivered.
- Error and reset:
  - inject u_res_valid, tag 1, with cnt[1]=0 → err=1 and stays high;
  - assert rst_n low mid-traffic → all outputs return to reset values immediately.
